// File: rtl/addsub_seq.sv
// Sequential add/subtract/compare unit for the RV32 datapath.
// Operands are processed CHUNK bits per clock, LSB slice first, with the
// carry rippled between slices through a register. Result and status flags
// are registered once the final slice has been summed.
module addsub_seq #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         carryout,
    output logic         overflow,
    output logic         zero,
    output logic         negative
);

    localparam int K  = N / CHUNK;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SLT  = 2'b10;
    localparam logic [1:0] OP_SLTU = 2'b11;

    // A width that is not a whole number of slices cannot be swept.
    if ((N % CHUNK) != 0 || CHUNK > N) begin : g_bad_chunk
        $error("addsub_seq: N must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    x_q;          // shifts right one slice per RUN cycle
    logic [N-1:0]    y_q;          // Y or ~Y, shifted like x_q
    logic [N-1:0]    sum_q;        // slices enter at the top and move down
    logic            x_msb_q;      // operand sign bits kept for overflow
    logic            y_msb_q;
    logic [1:0]      op_q;
    logic            carry_q;
    logic [CW-1:0]   cnt_q;

    logic            last_slice;
    logic [CHUNK:0]  slice_add;
    logic [N-1:0]    sum_next;
    logic            ovf_next;
    logic [N-1:0]    result_next;

    assign last_slice = (cnt_q == CW'(K - 1));
    assign slice_add  = {1'b0, x_q[CHUNK-1:0]} + {1'b0, y_q[CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, carry_q};

    // After K shifts the first slice has arrived at bit 0.
    if (K == 1) begin : g_single
        assign sum_next = slice_add[CHUNK-1:0];
    end else begin : g_multi
        assign sum_next = {slice_add[CHUNK-1:0], sum_q[N-1:CHUNK]};
    end

    assign ovf_next = (x_msb_q == y_msb_q) && (sum_next[N-1] != x_msb_q);

    // Compare ops return a single bit; flags always come from the raw sum.
    always_comb begin
        result_next = sum_next;
        case (op_q)
            OP_SLT:  result_next = {{(N-1){1'b0}}, sum_next[N-1] ^ ovf_next};
            OP_SLTU: result_next = {{(N-1){1'b0}}, ~slice_add[CHUNK]};
            default: result_next = sum_next;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last_slice) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, slice ripple and final result/flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            sum_q    <= '0;
            x_msb_q  <= 1'b0;
            y_msb_q  <= 1'b0;
            op_q     <= OP_ADD;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result   <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q     <= X;
                        y_q     <= (op == OP_ADD) ? Y : ~Y;
                        x_msb_q <= X[N-1];
                        y_msb_q <= (op == OP_ADD) ? Y[N-1] : ~Y[N-1];
                        op_q    <= op;
                        carry_q <= (op != OP_ADD);
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    x_q     <= x_q >> CHUNK;
                    y_q     <= y_q >> CHUNK;
                    sum_q   <= sum_next;
                    carry_q <= slice_add[CHUNK];
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_slice) begin
                        result   <= result_next;
                        carryout <= slice_add[CHUNK];
                        overflow <= ovf_next;
                        zero     <= (sum_next == '0);
                        negative <= sum_next[N-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
